// File: rtl/d20_roll_scheduler_if.sv
// rtl/d20_roll_scheduler_if.sv - request, imem and response signals of the shared d20 roll scheduler
interface d20_roll_scheduler_if #(
  parameter int NUM_BITS  = 8,
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 6
);
  localparam int ID_BITS = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*NUM_BITS-1:0] mod_flat;
  logic [NUM_REQ*NUM_BITS-1:0] target_flat;
  logic [NUM_REQ*2-1:0]        mode_flat;
  logic [ADDR_BITS-1:0]        mem_addr;
  logic [4:0]                  mem_rdata;
  logic [NUM_REQ-1:0]          grant;
  logic                        busy;
  logic                        resp_valid;
  logic [ID_BITS-1:0]          resp_id;
  logic [4:0]                  resp_roll;
  logic [NUM_BITS-1:0]         resp_final;
  logic                        resp_hit;
  logic [1:0]                  resp_crit;

  modport master (
    output req, mod_flat, target_flat, mode_flat, mem_rdata,
    input  mem_addr, grant, busy, resp_valid, resp_id, resp_roll, resp_final, resp_hit, resp_crit
  );

  modport slave (
    input  req, mod_flat, target_flat, mode_flat, mem_rdata,
    output mem_addr, grant, busy, resp_valid, resp_id, resp_roll, resp_final, resp_hit, resp_crit
  );
endinterface

// File: rtl/d20_roll_scheduler.sv
// rtl/d20_roll_scheduler.sv - round-robin shared d20 roller over one imem read port
module d20_roll_scheduler #(
  parameter int NUM_BITS  = 8,
  parameter int NUM_REQ   = 4,
  parameter int MEM_DEPTH = 64,
  parameter int ADDR_BITS = 6
) (
  input logic                  clk,
  input logic                  reset,
  d20_roll_scheduler_if.slave  bus
);
  localparam int ID_BITS = $clog2(NUM_REQ);
  localparam logic signed [NUM_BITS:0] SAT_MAX = {2'b00, {(NUM_BITS-1){1'b1}}};
  localparam logic signed [NUM_BITS:0] SAT_MIN = {2'b11, {(NUM_BITS-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, FETCH1, FETCH2, CALC, RESP} state_t;

  state_t                      state, state_n;
  logic [ADDR_BITS-1:0]        rd_ptr, rd_ptr_next;
  logic [ID_BITS-1:0]          last_id, id_q;
  logic signed [NUM_BITS-1:0]  mod_q, target_q;
  logic [1:0]                  mode_q;
  logic [4:0]                  face1, face2, sel_face;
  logic                        two_faces;
  logic                        pick_valid;
  logic [ID_BITS-1:0]          pick_id, rr_idx;
  logic signed [NUM_BITS:0]    sum;
  logic signed [NUM_BITS-1:0]  final_val;
  logic                        hit_val;
  logic [1:0]                  crit_val;

  logic signed [NUM_BITS-1:0]  mod_arr    [NUM_REQ];
  logic signed [NUM_BITS-1:0]  target_arr [NUM_REQ];
  logic [1:0]                  mode_arr   [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign mod_arr[g]    = bus.mod_flat[g*NUM_BITS +: NUM_BITS];
    assign target_arr[g] = bus.target_flat[g*NUM_BITS +: NUM_BITS];
    assign mode_arr[g]   = bus.mode_flat[g*2 +: 2];
  end

  function automatic logic [4:0] map_face(input logic [4:0] raw);
    map_face = ((raw >= 5'd20) ? (raw - 5'd20) : raw) + 5'd1;
  endfunction

  // Offset 1 is written last so the requester right after last_id wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    rr_idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_idx = ID_BITS'((int'(last_id) + k) % NUM_REQ);
      if (bus.req[rr_idx]) begin
        pick_valid = 1'b1;
        pick_id    = rr_idx;
      end
    end
  end

  assign rd_ptr_next = (rd_ptr == ADDR_BITS'(MEM_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
  assign two_faces   = (mode_q == 2'b01) || (mode_q == 2'b10);

  always_comb begin
    case (mode_q)
      2'b01:   sel_face = (face1 > face2) ? face1 : face2;
      2'b10:   sel_face = (face1 < face2) ? face1 : face2;
      default: sel_face = face1;
    endcase
    sum = $signed({{(NUM_BITS-4){1'b0}}, sel_face}) + $signed({mod_q[NUM_BITS-1], mod_q});
    if (sum > SAT_MAX)      final_val = SAT_MAX[NUM_BITS-1:0];
    else if (sum < SAT_MIN) final_val = SAT_MIN[NUM_BITS-1:0];
    else                    final_val = sum[NUM_BITS-1:0];
    if (sel_face == 5'd20) begin
      hit_val  = 1'b1;
      crit_val = 2'b01;
    end else if (sel_face == 5'd1) begin
      hit_val  = 1'b0;
      crit_val = 2'b10;
    end else begin
      hit_val  = (final_val >= target_q);
      crit_val = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pick_valid) state_n = FETCH1;
      FETCH1:  state_n = two_faces ? FETCH2 : CALC;
      FETCH2:  state_n = CALC;
      CALC:    state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.grant      = '0;
    bus.busy       = (state != IDLE);
    bus.resp_valid = (state == RESP);
    bus.mem_addr   = rd_ptr;
    if (state == IDLE && pick_valid && !reset)
      bus.grant = NUM_REQ'(1) << pick_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr         <= '0;
      last_id        <= ID_BITS'(NUM_REQ - 1);
      id_q           <= '0;
      mod_q          <= '0;
      target_q       <= '0;
      mode_q         <= '0;
      face1          <= '0;
      face2          <= '0;
      bus.resp_id    <= '0;
      bus.resp_roll  <= '0;
      bus.resp_final <= '0;
      bus.resp_hit   <= 1'b0;
      bus.resp_crit  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            last_id  <= pick_id;
            id_q     <= pick_id;
            mod_q    <= mod_arr[pick_id];
            target_q <= target_arr[pick_id];
            mode_q   <= mode_arr[pick_id];
            rd_ptr   <= rd_ptr_next;
          end
        end
        FETCH1: begin
          face1 <= map_face(bus.mem_rdata);
          if (two_faces) rd_ptr <= rd_ptr_next;
        end
        FETCH2: face2 <= map_face(bus.mem_rdata);
        CALC: begin
          bus.resp_id    <= id_q;
          bus.resp_roll  <= sel_face;
          bus.resp_final <= final_val;
          bus.resp_hit   <= hit_val;
          bus.resp_crit  <= crit_val;
        end
        default: ;
      endcase
    end
  end
endmodule
